pulse_gen_multi: RTL and testbench
==================================

PULSE_GEN_MULTI -- requirements
Module: pulse_gen_multi

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 50_000_000, which is the input clock frequency in Hz and the reset divisor of every channel.
REQ-002 The module SHALL have parameter NUM_CH, default 4, which is the number of independent tick channels (legal range 1..16).
REQ-003 The module SHALL have parameter DIV_W, default 32, which is the divisor width (must be >= $clog2(CLK_FREQ+1)).
REQ-004 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  NUM_CH  per-channel run enable, level.
REQ-007 sync_clr  input  1  one-cycle strobe that restarts all channels phase-aligned.
REQ-008 cfg_we  input  1  divisor write strobe, one cycle.
REQ-009 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
REQ-010 cfg_div  input  DIV_W  new divisor D for the target channel.
REQ-011 tick  output  NUM_CH  per-channel registered one-cycle pulse, once every D cycles.
REQ-012 sq  output  NUM_CH  per-channel registered square wave with period D.
REQ-013 pend  output  NUM_CH  per-channel flag: a written divisor is waiting to be applied.

Function
REQ-014 Each channel SHALL hold an active divisor, a shadow divisor, a pend bit and a counter cnt of DIV_W bits.
REQ-015 While en[i]=1 and the active D>=1, cnt SHALL step 0,1,...,D-1,0,... with one step per clock.
REQ-016 tick[i] SHALL be 1 in exactly the cycle after the edge where cnt==D-1, and 0 otherwise.
REQ-017 With en sampled high at edge 0 from cnt=0, the first tick SHALL be high after edge D, then every D cycles.
REQ-018 sq[i] SHALL be registered as (next cnt < D>>1); high for floor(D/2) and low for ceil(D/2) cycles per period.
REQ-019 D==1 SHALL give tick constantly 1 and sq constantly 0.
REQ-020 D==0 SHALL hold the channel idle: cnt=0, tick=0, sq=0.
REQ-021 en[i]=0 SHALL force cnt=0, tick=0 and sq=0 on the next edge; re-enable behaves per REQ-017.
REQ-022 cfg_we with cfg_ch<NUM_CH SHALL load the shadow divisor and set pend; cfg_ch>=NUM_CH SHALL be ignored.
REQ-023 A pending shadow SHALL be copied to active and pend cleared at the wrap edge (cnt==D-1), or on the next edge if en[i]=0, D==0, or sync_clr=1.
REQ-024 If cfg_we targets a channel on its wrap edge, the written value SHALL become active at that edge (bypass) and pend SHALL stay 0.
REQ-025 Repeated writes before application SHALL overwrite the shadow; only the last value is applied.
REQ-026 The divisor in force SHALL never change mid-period, so no tick is shortened or duplicated.
REQ-027 sync_clr SHALL set all cnt=0 and tick=0, sq=0 for one cycle and apply all pending shadows; it SHALL have priority over wrap and cfg apply.
REQ-028 Channels SHALL be fully independent except for sync_clr and the shared config port.
REQ-029 Arithmetic SHALL be unsigned DIV_W-bit; D-1 SHALL be computed only for D>=1.

Reset
REQ-030 While rst_n=0, every active and shadow divisor SHALL be CLK_FREQ, and cnt=0, tick=0, sq=0, pend=0.
REQ-031 Reset asserted mid-period SHALL abort the period immediately, with no tick emitted.
REQ-032 After rst_n deasserts with en=all-ones, each channel SHALL tick first after edge CLK_FREQ, with legacy 1 Hz timing.

Verification
REQ-033 Reset: CLK_FREQ=10, NUM_CH=4, en=4'hF -> tick=4'hF in cycles 10, 20, 30; sq high for 5 of every 10 cycles; pend=0.
REQ-034 Reprogram: write ch1 D=4 at cycle 3 -> pend[1]=1 until the cycle-10 tick, then tick[1] at 14, 18, 22; other channels unchanged.
REQ-035 Bypass: write ch2 D=3 on its wrap edge -> pend[2] stays 0, tick[2] 3 cycles after the wrap; write to cfg_ch=5 with NUM_CH=4 -> no effect.
REQ-036 Edge divisors: D=1 -> tick constant 1, sq 0; D=0 -> tick=0 and sq=0 forever; D=5 -> sq high 2 and low 3 cycles.
REQ-037 Sync and enable: channels with D=4 and D=6, sync_clr at cycle 7 -> both ticks coincide at cycle 19 (lcm 12); en[0] low for 3 cycles -> tick[0] D cycles after re-enable.
REQ-038 Reset mid-operation: rst_n low at cnt=7 with D=10 -> outputs 0 immediately, divisors back to CLK_FREQ, pending write discarded.

Source files
------------

// File: rtl/pulse_gen_multi_if.sv
// rtl/pulse_gen_multi_if.sv - control/status bundle of the multi-channel tick generator
//
// Ports (master drives controls, slave drives status):
//   en[NUM_CH]     per-channel run enable, level
//   sync_clr       one-cycle strobe restarting all channels phase-aligned
//   cfg_we         divisor write strobe
//   cfg_ch         target channel of the write (out-of-range values ignored)
//   cfg_div        new divisor
//   tick[NUM_CH]   one-cycle pulse once every D cycles
//   sq[NUM_CH]     square wave with period D
//   pend[NUM_CH]   a written divisor is waiting to be applied
interface pulse_gen_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq;
    logic [NUM_CH-1:0] pend;

    modport master (
        output en, sync_clr, cfg_we, cfg_ch, cfg_div,
        input  tick, sq, pend
    );

    modport slave (
        input  en, sync_clr, cfg_we, cfg_ch, cfg_div,
        output tick, sq, pend
    );
endinterface

// File: rtl/pulse_gen_multi.sv
// rtl/pulse_gen_multi.sv - NUM_CH independent programmable tick / square-wave generators
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pulse_gen_multi_if slave: en, sync_clr, cfg_we/cfg_ch/cfg_div in;
//          tick, sq, pend out (all outputs registered)
module pulse_gen_multi #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_gen_multi_if.slave  bus
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(CLK_FREQ);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    // Zero-extended so that channel indices beyond NUM_CH never match.
    logic [31:0] cfg_ch_ext;
    assign cfg_ch_ext = 32'(bus.cfg_ch);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] shd_q, shd_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] last;
        logic             pend_q, pend_d;
        logic             tick_q, tick_d;
        logic             sq_q, sq_d;
        logic             hit, run, wrap;

        assign hit  = bus.cfg_we && (cfg_ch_ext == 32'(g));
        assign run  = bus.en[g] && (act_q != '0);
        assign last = (act_q != '0) ? act_q - ONE : '0;
        // sync_clr outranks the wrap, so a wrap edge coinciding with it is just a restart.
        assign wrap = run && !bus.sync_clr && (cnt_q == last);

        always_comb begin
            act_d  = act_q;
            shd_d  = shd_q;
            pend_d = pend_q;
            cnt_d  = '0;
            tick_d = 1'b0;
            sq_d   = 1'b0;

            if (bus.sync_clr || !run) begin
                // Idle or restart edge: safe point to swap divisors, outputs held low.
                if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
                if (hit) begin
                    shd_d  = bus.cfg_div;
                    pend_d = 1'b1;
                end
            end else if (wrap) begin
                // Period boundary: a write landing here takes effect directly.
                if (hit) begin
                    act_d  = bus.cfg_div;
                    shd_d  = bus.cfg_div;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
                tick_d = 1'b1;
                sq_d   = (act_d >> 1) != '0;
            end else begin
                if (hit) begin
                    shd_d  = bus.cfg_div;
                    pend_d = 1'b1;
                end
                cnt_d = cnt_q + ONE;
                sq_d  = cnt_d < (act_q >> 1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_q  <= RST_DIV;
                shd_q  <= RST_DIV;
                cnt_q  <= '0;
                pend_q <= 1'b0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                act_q  <= act_d;
                shd_q  <= shd_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                tick_q <= tick_d;
                sq_q   <= sq_d;
            end
        end

        assign bus.tick[g] = tick_q;
        assign bus.sq[g]   = sq_q;
        assign bus.pend[g] = pend_q;
    end
endmodule

// File: tb/tb_pulse_gen_multi.sv
// tb/tb_pulse_gen_multi.sv - directed self-checking bench for pulse_gen_multi
module tb_pulse_gen_multi;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [3:0] et, es, ep;
    logic [4:0] et5;
    int         c1;

    pulse_gen_multi_if #(.NUM_CH(4), .DIV_W(8)) bus ();
    pulse_gen_multi_if #(.NUM_CH(5), .DIV_W(8)) bus5 ();

    pulse_gen_multi #(.CLK_FREQ(10), .NUM_CH(4), .DIV_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    pulse_gen_multi #(.CLK_FREQ(10), .NUM_CH(5), .DIV_W(8)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic enter_reset(input logic [3:0] en_v);
        rst_n        = 1'b0;
        bus.en       = en_v;
        bus.sync_clr = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_div  = '0;
        bus5.en       = 5'h1F;
        bus5.sync_clr = 1'b0;
        bus5.cfg_we   = 1'b0;
        bus5.cfg_ch   = '0;
        bus5.cfg_div  = '0;
        step();
        step();
    endtask

    initial begin
        clk = 1'b0;

        // Reset state and legacy timing, with a ch1 reprogram at cycle 3
        enter_reset(4'hF);
        chk("rst_tick", 0, 32'(bus.tick), 32'h0);
        chk("rst_sq",   0, 32'(bus.sq),   32'h0);
        chk("rst_pend", 0, 32'(bus.pend), 32'h0);
        rst_n = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            step();
            et = ((e % 10) == 0) ? 4'hD : 4'h0;
            es = ((e % 10) < 5)  ? 4'hD : 4'h0;
            c1 = (e < 10) ? e : (e - 10) % 4;
            et[1] = (e >= 10) && (c1 == 0);
            es[1] = (e < 10) ? (e < 5) : (c1 < 2);
            ep = (e >= 3 && e < 10) ? 4'b0010 : 4'b0000;
            chk("A_tick", e, 32'(bus.tick), 32'(et));
            chk("A_sq",   e, 32'(bus.sq),   32'(es));
            chk("A_pend", e, 32'(bus.pend), 32'(ep));
            if (e == 2) begin
                bus.cfg_we  = 1'b1;
                bus.cfg_ch  = 2'd1;
                bus.cfg_div = 8'd4;
            end
            if (e == 3) bus.cfg_we = 1'b0;
        end

        // Bypass write on ch2 wrap edge; out-of-range writes on the 5-channel instance
        enter_reset(4'hF);
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            step();
            et = (e == 10) ? 4'hF : 4'h0;
            if (e == 13 || e == 16) et[2] = 1'b1;
            et5 = (e == 10) ? 5'h1F : 5'h00;
            chk("B_tick",  e, 32'(bus.tick),  32'(et));
            chk("B_pend",  e, 32'(bus.pend),  32'h0);
            chk("B_tick5", e, 32'(bus5.tick), 32'(et5));
            chk("B_pend5", e, 32'(bus5.pend), 32'h0);
            if (e == 9) begin
                bus.cfg_we  = 1'b1;
                bus.cfg_ch  = 2'd2;
                bus.cfg_div = 8'd3;
            end
            if (e == 10) bus.cfg_we = 1'b0;
            if (e == 1) begin
                bus5.cfg_we  = 1'b1;
                bus5.cfg_ch  = 3'd5;
                bus5.cfg_div = 8'd3;
            end
            if (e == 2) begin
                bus5.cfg_ch  = 3'd7;
                bus5.cfg_div = 8'd2;
            end
            if (e == 3) bus5.cfg_we = 1'b0;
        end

        // Edge divisors D=1, D=0, D=5 loaded while disabled
        enter_reset(4'h0);
        rst_n = 1'b1;
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 2'd0;
        bus.cfg_div = 8'd1;
        for (int e = 1; e <= 4; e++) begin
            step();
            ep = (e == 4) ? 4'b0000 : 4'(1 << (e - 1));
            chk("C_pend", e, 32'(bus.pend), 32'(ep));
            chk("C_idle", e, 32'(bus.tick), 32'h0);
            if (e == 1) begin
                bus.cfg_ch  = 2'd1;
                bus.cfg_div = 8'd0;
            end
            if (e == 2) begin
                bus.cfg_ch  = 2'd2;
                bus.cfg_div = 8'd5;
            end
            if (e == 3) bus.cfg_we = 1'b0;
            if (e == 4) bus.en = 4'hF;
        end
        for (int f = 1; f <= 15; f++) begin
            step();
            et = 4'b0001;
            es = 4'b0000;
            et[2] = (f % 5) == 0;
            es[2] = (f % 5) < 2;
            et[3] = (f == 10);
            es[3] = (f % 10) < 5;
            chk("C_tick", f, 32'(bus.tick), 32'(et));
            chk("C_sq",   f, 32'(bus.sq),   32'(es));
            chk("C_pend", f, 32'(bus.pend), 32'h0);
        end

        // sync_clr alignment of D=4 / D=6, then en[0] dropped for 3 cycles
        enter_reset(4'h0);
        rst_n = 1'b1;
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = 2'd0;
        bus.cfg_div = 8'd4;
        for (int e = 1; e <= 3; e++) begin
            step();
            if (e == 1) begin
                bus.cfg_ch  = 2'd1;
                bus.cfg_div = 8'd6;
            end
            if (e == 2) bus.cfg_we = 1'b0;
            if (e == 3) begin
                chk("D_pend", e, 32'(bus.pend), 32'h0);
                bus.en = 4'hF;
            end
        end
        for (int f = 1; f <= 31; f++) begin
            step();
            et = 4'h0;
            et[0] = (f == 4) || (f == 11) || (f == 15) || (f == 19) || (f == 27) || (f == 31);
            et[1] = (f == 6) || (f == 13) || (f == 19) || (f == 25) || (f == 31);
            et[2] = (f == 17) || (f == 27);
            et[3] = (f == 17) || (f == 27);
            chk("D_tick", f, 32'(bus.tick), 32'(et));
            if (f == 7) chk("D_sync_sq", f, 32'(bus.sq), 32'h0);
            if (f >= 21 && f <= 23) chk("D_dis_sq0", f, 32'(bus.sq[0]), 32'h0);
            if (f == 6)  bus.sync_clr = 1'b1;
            if (f == 7)  bus.sync_clr = 1'b0;
            if (f == 20) bus.en = 4'hE;
            if (f == 23) bus.en = 4'hF;
        end

        // Asynchronous reset at cnt=7 with a write pending on ch1
        enter_reset(4'hF);
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 1) begin
                bus.cfg_we  = 1'b1;
                bus.cfg_ch  = 2'd1;
                bus.cfg_div = 8'd4;
            end
            if (e == 2) bus.cfg_we = 1'b0;
        end
        chk("E_pend_before", 7, 32'(bus.pend), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("E_async_tick", 7, 32'(bus.tick), 32'h0);
        chk("E_async_sq",   7, 32'(bus.sq),   32'h0);
        chk("E_async_pend", 7, 32'(bus.pend), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            et = (e == 10) ? 4'hF : 4'h0;
            es = ((e % 10) < 5) ? 4'hF : 4'h0;
            chk("E_tick", e, 32'(bus.tick), 32'(et));
            chk("E_sq",   e, 32'(bus.sq),   32'(es));
            chk("E_pend", e, 32'(bus.pend), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
